// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and ALU functions for the multicycle controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_t;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_JMP  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode classifier
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] i_opcode,
    output logic           o_is_alu,
    output logic           o_is_addi,
    output logic           o_is_lw,
    output logic           o_is_sw,
    output logic           o_is_beq,
    output logic           o_is_jmp,
    output logic           o_is_halt,
    output logic           o_is_illegal
);

    assign o_is_alu     = (i_opcode == OPW'(OP_ALU));
    assign o_is_addi    = (i_opcode == OPW'(OP_ADDI));
    assign o_is_lw      = (i_opcode == OPW'(OP_LW));
    assign o_is_sw      = (i_opcode == OPW'(OP_SW));
    assign o_is_beq     = (i_opcode == OPW'(OP_BEQ));
    assign o_is_jmp     = (i_opcode == OPW'(OP_JMP));
    assign o_is_halt    = (i_opcode == OPW'(OP_HALT));
    assign o_is_illegal = ~(o_is_alu | o_is_addi | o_is_lw | o_is_sw |
                            o_is_beq | o_is_jmp | o_is_halt);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control unit: PC, IR, fetch handshake and sequencing
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          OPW      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        sel_ext,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    input  logic [31:0] imm_ext,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic        mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        halted,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_inc;
    logic [31:0] r_ir;
    logic        r_illegal;
    logic        w_ir_load;
    logic        w_set_illegal;

    logic w_is_alu;
    logic w_is_addi;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_jmp;
    logic w_is_halt;
    logic w_is_illegal;

    ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .i_opcode     (r_ir[31:32-OPW]),
        .o_is_alu     (w_is_alu),
        .o_is_addi    (w_is_addi),
        .o_is_lw      (w_is_lw),
        .o_is_sw      (w_is_sw),
        .o_is_beq     (w_is_beq),
        .o_is_jmp     (w_is_jmp),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    assign w_pc_inc = r_pc + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir <= imem_rdata;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_load     = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_is_jmp) begin
                    w_pc_nxt    = imm_ext;
                    w_state_nxt = ST_FETCH;
                end else if (w_is_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_is_illegal) begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = ST_HALTED;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_alu || w_is_addi) begin
                    w_state_nxt = ST_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    // Only BEQ reaches here; offset is zero-extended so branches go forward only.
                    w_pc_nxt    = alu_zero ? (w_pc_inc + imm_ext) : w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (w_is_lw) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = ST_FETCH;
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ALU controls follow ir so they stay stable through EXEC, MEM and WB.
    always_comb begin
        alu_op = ALU_ADD;
        if (w_is_alu) begin
            alu_op = r_ir[3:0];
        end else if (w_is_beq) begin
            alu_op = ALU_SUB;
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign sel_ext     = w_is_jmp;
    assign imm16       = r_ir[15:0];
    assign imm26       = r_ir[25:0];
    assign alu_src_imm = w_is_addi | w_is_lw | w_is_sw;
    assign rf_we       = (r_state == ST_WB);
    assign mem_to_reg  = w_is_lw;
    assign dmem_req    = (r_state == ST_MEM);
    assign dmem_we     = (r_state == ST_MEM) & w_is_sw;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign halted      = (r_state == ST_HALTED);
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - instruction-level reference model and per-cycle compare for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int A_NONE  = 0;
    localparam int A_FETCH = 1;
    localparam int A_MEM   = 2;
    localparam int A_WB    = 3;
    localparam int A_HALT  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        sel_ext;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_ext;
    logic        alu_zero;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_we;
    logic        mem_to_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        halted;
    logic        illegal;

    int          total = 0;
    int          bad = 0;
    logic        check_en = 1'b0;
    logic        idle_phase = 1'b1;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ir = 32'h0;
    logic        m_illegal = 1'b0;
    int          m_act = A_NONE;

    multicycle_ctrl #(
        .RESET_PC (32'h0000_0000),
        .OPW      (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .sel_ext     (sel_ext),
        .imm16       (imm16),
        .imm26       (imm26),
        .imm_ext     (imm_ext),
        .alu_zero    (alu_zero),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .rf_we       (rf_we),
        .mem_to_reg  (mem_to_reg),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .pc          (pc),
        .ir          (ir),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Zero-extending immediate extender attached to the controller.
    assign imm_ext = sel_ext ? {6'b0, imm26} : {16'b0, imm16};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [5:0] op;
        if (check_en) begin
            op = m_ir[31:26];
            chk("imem_req",    {31'b0, imem_req},    {31'b0, m_act == A_FETCH});
            chk("imem_addr",   imem_addr,            m_pc);
            chk("pc",          pc,                   m_pc);
            chk("ir",          ir,                   m_ir);
            chk("dmem_req",    {31'b0, dmem_req},    {31'b0, m_act == A_MEM});
            chk("dmem_we",     {31'b0, dmem_we},     {31'b0, m_act == A_MEM && op == 6'h03});
            chk("rf_we",       {31'b0, rf_we},       {31'b0, m_act == A_WB});
            chk("halted",      {31'b0, halted},      {31'b0, m_act == A_HALT});
            chk("illegal",     {31'b0, illegal},     {31'b0, m_illegal});
            chk("sel_ext",     {31'b0, sel_ext},     {31'b0, op == 6'h05});
            chk("imm16",       {16'b0, imm16},       {16'b0, m_ir[15:0]});
            chk("imm26",       {6'b0, imm26},        {6'b0, m_ir[25:0]});
            chk("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, op == 6'h01 || op == 6'h02 || op == 6'h03});
            chk("alu_op",      {28'b0, alu_op},      {28'b0, (op == 6'h00) ? m_ir[3:0] : (op == 6'h04) ? 4'h1 : 4'h0});
            chk("mem_to_reg",  {31'b0, mem_to_reg},  {31'b0, op == 6'h02});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start    = idle_phase ? 1'b0 : ($urandom_range(0, 3) == 0);
        alu_zero = $urandom_range(0, 1) == 1;
    endtask

    task automatic do_reset();
        idle_phase = 1'b1;
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        tick();
        m_pc      = 32'h0;
        m_ir      = 32'h0;
        m_illegal = 1'b0;
        m_act     = A_NONE;
        check_en  = 1'b1;
        rst_n     = 1'b1;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1;
        idle_phase = 1'b0;
        start      = 1'b0;
        m_act      = A_FETCH;
    endtask

    // Entered in a FETCH cycle; returns in the next FETCH cycle or in HALTED.
    task automatic run_instr(input logic [31:0] instr, input int fd, input int md, input logic z);
        logic [5:0] op;
        op = instr[31:26];
        for (int i = 0; i < fd; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_ir       = instr;
        m_act      = A_NONE;
        if (op == 6'h05) begin
            tick();
            m_pc  = {6'b0, instr[25:0]};
            m_act = A_FETCH;
        end else if (op == 6'h3F) begin
            tick();
            m_act = A_HALT;
        end else if (op > 6'h05) begin
            tick();
            m_illegal = 1'b1;
            m_act     = A_HALT;
        end else begin
            tick();
            alu_zero = z;
            tick();
            if (op == 6'h04) begin
                m_pc  = m_pc + 32'd1 + (z ? {16'b0, instr[15:0]} : 32'h0);
                m_act = A_FETCH;
            end else if (op == 6'h00 || op == 6'h01) begin
                m_act = A_WB;
                tick();
                m_pc  = m_pc + 32'd1;
                m_act = A_FETCH;
            end else begin
                m_act = A_MEM;
                for (int i = 0; i < md; i++) begin
                    dmem_ack = 1'b0;
                    tick();
                end
                dmem_ack = 1'b1;
                tick();
                dmem_ack = 1'b0;
                if (op == 6'h02) begin
                    m_act = A_WB;
                    tick();
                end
                m_pc  = m_pc + 32'd1;
                m_act = A_FETCH;
            end
        end
    endtask

    initial begin
        logic [31:0] instr;
        logic [5:0]  op;
        int          r;
        rst_n      = 1'b0;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        alu_zero   = 1'b0;
        dmem_ack   = 1'b0;
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        for (int i = 0; i < 3; i++) tick();

        start_run();
        chk("first_fetch_req", {31'b0, imem_req}, 32'h1);
        run_instr(32'h0400_0005, 0, 0, 1'b0);
        chk("addi_pc", pc, 32'h0000_0001);

        run_instr(32'h1400_0123, 0, 0, 1'b0);
        chk("jmp_pc", pc, 32'h0000_0123);
        chk("jmp_fetch_addr", imem_addr, 32'h0000_0123);

        run_instr(32'h1400_0010, 1, 0, 1'b0);
        run_instr(32'h1000_0004, 0, 0, 1'b1);
        chk("beq_taken_pc", pc, 32'h0000_0015);
        run_instr(32'h1400_0010, 0, 0, 1'b0);
        run_instr(32'h1000_0004, 2, 0, 1'b0);
        chk("beq_not_taken_pc", pc, 32'h0000_0011);

        run_instr(32'h0800_0002, 0, 3, 1'b0);
        chk("lw_pc", pc, 32'h0000_0012);
        run_instr(32'h0C00_0000, 1, 2, 1'b0);
        chk("sw_pc", pc, 32'h0000_0013);

        // Reset lands on the same edge as the fetch ack.
        run_instr(32'h1400_0040, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b0;
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        do_reset();
        chk("rst_ack_req", {31'b0, imem_req}, 32'h0);
        chk("rst_ack_ir", ir, 32'h0);
        chk("rst_ack_pc", pc, 32'h0);

        start_run();
        run_instr(32'hA800_0000, 0, 0, 1'b0);
        chk("illegal_flag", {31'b0, illegal}, 32'h1);
        chk("illegal_halted", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            start = i[0];
        end
        chk("halted_no_req", {31'b0, imem_req}, 32'h0);
        do_reset();
        chk("illegal_cleared", {31'b0, illegal}, 32'h0);
        start_run();

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 16)      op = 6'h00;
            else if (r < 32) op = 6'h01;
            else if (r < 48) op = 6'h02;
            else if (r < 64) op = 6'h03;
            else if (r < 82) op = 6'h04;
            else if (r < 95) op = 6'h05;
            else if (r < 97) op = 6'h3F;
            else             op = 6'($urandom_range(6, 62));
            instr = {op, 26'($urandom)};
            run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            if (m_act == A_HALT) begin
                for (int i = 0; i < 4; i++) tick();
                do_reset();
                start_run();
            end
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the filter processor core.
- Owns the PC and the instruction register, fetches over a req/ack instruction-memory handshake, and decodes the opcode.
- Drives the immediate extender (select plus 16/26-bit fields) and consumes its 32-bit result for branch and jump targets.
- Sequences register-file, ALU and data-memory control per instruction class.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address).
- OPW, 6, opcode field width (bits [31:26]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching at PC.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- sel_ext  out  1  extender select: 1 = 26-bit field, 0 = 16-bit field.
- imm16  out  16  ir[15:0].
- imm26  out  26  ir[25:0].
- imm_ext  in  32  zero-extended immediate from the extender (combinational).
- alu_zero  in  1  ALU zero flag.
- alu_op  out  4  ALU function.
- alu_src_imm  out  1  ALU B operand is imm_ext.
- rf_we  out  1  register-file write strobe (1 cycle).
- mem_to_reg  out  1  writeback source is data memory.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  data-memory write.
- dmem_ack  in  1  data-memory complete.
- pc  out  32  current PC.
- ir  out  32  instruction register.
- halted  out  1  core stopped.
- illegal  out  1  sticky: stopped on an undefined opcode.

Behaviour:
- **Reset** (rst_n=0 at clk edge, any state):
  - state=IDLE, pc=RESET_PC, ir=0.
  - Every output strobe is 0, including imem_req and dmem_req, which drop on that same edge even mid-handshake.
  - halted=0, illegal=0.
- **Opcodes** (ir[31:26]):
  - 00 ALU reg (alu_op=ir[3:0]).
  - 01 ADDI.
  - 02 LW.
  - 03 SW.
  - 04 BEQ.
  - 05 JMP.
  - 3F HALT.
  - Any other value is illegal.
- **sel_ext**: 1 only when ir opcode = JMP, else 0. imm16 and imm26 are pure slices of ir.
- **States and transitions**:
  - IDLE: start=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Req is held stable until imem_ack. On ack: ir<=imem_rdata, -> DECODE. An ack in the first FETCH cycle is legal.
  - DECODE:
    - JMP: pc<=imm_ext, -> FETCH.
    - HALT: -> HALTED.
    - Illegal: illegal<=1, -> HALTED.
    - Otherwise -> EXEC.
  - EXEC: alu_src_imm = (ADDI|LW|SW); alu_op=ADD(4'h0) for ADDI/LW/SW, SUB(4'h1) for BEQ.
    - ALU/ADDI -> WB.
    - LW/SW -> MEM.
    - BEQ: pc <= alu_zero ? pc+1+imm_ext : pc+1, -> FETCH.
  - MEM: dmem_req=1, dmem_we=(SW), held until dmem_ack.
    - On ack, LW -> WB.
    - On ack, SW: pc<=pc+1, -> FETCH.
  - WB: rf_we=1 for exactly one cycle, mem_to_reg=(LW), pc<=pc+1, -> FETCH.
  - HALTED: halted=1. Only reset exits; start is ignored.
- **Arithmetic**: PC is word-addressed and all PC arithmetic is mod 2^32. pc=FFFF_FFFF +1 wraps to 0 with no flag. The branch offset is zero-extended (forward-only branches).
- **Latency with zero-wait memories**: ALU/ADDI 4 cycles, LW 5, SW 4, BEQ 3, JMP 2.
- **Output timing**: all control outputs are decoded from state and ir (Moore). No output depends combinationally on an ack, so imem_req/dmem_req never glitch within a cycle.
- **start during non-IDLE states**: ignored.
- **Simultaneous ack and reset**: reset wins; ir is not loaded.

Decomposition:
- Shared package ctrl_pkg:
  - State enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - Opcode localparams OP_ALU…OP_HALT.
  - ALU function constants ALU_ADD, ALU_SUB.
- Natural sub-module: ctrl_decode, combinational opcode -> {is_alu, is_addi, is_lw, is_sw, is_beq, is_jmp, is_halt, is_illegal}.
- The top module holds the FSM, PC and IR.

Test Plan:
- Reset, then start with zero-wait imem; ir = ADDI (32'h0400_0005) -> imem_req in cycle 1, rf_we pulses exactly one cycle at cycle 4, alu_src_imm=1 in EXEC, pc 0->1.
- JMP 32'h1400_0123 -> sel_ext=1 in DECODE, pc=32'h0000_0123 next cycle, immediately followed by FETCH at addr 0x123.
- BEQ at pc=0x10 with imm16=0x0004: alu_zero=1 -> pc=0x15; alu_zero=0 -> pc=0x11. sel_ext=0 throughout.
- LW with dmem_ack delayed 3 cycles -> dmem_req and dmem_we=0 held stable 3 cycles; WB follows with mem_to_reg=1; total 8 cycles.
- imem_ack delayed 5 cycles, rst_n=0 asserted on the cycle ack arrives -> imem_req=0 next edge, ir=0, pc=RESET_PC, state IDLE.
- Opcode 6'h2A -> illegal=1, halted=1; then start toggled -> no imem_req until reset, after which illegal=0.
